// File: rtl/elementcmd_pkg.sv
// Shared constants and types for the elementcmd command issuer: command word
// layout for the default configuration, a decoded-command struct, a packing
// helper for building command words, and the FSM state encoding.
package elementcmd_pkg;

    // Default field widths of the 128-bit command word
    localparam int TCNT_W = 27;
    localparam int ENV_W  = 12;
    localparam int FREQ_W = 9;
    localparam int AMPX_W = 16;
    localparam int PINI_W = 17;
    localparam int MODE_W = 2;
    localparam int CMD_WORD_W = 128;

    // Field offsets, packed LSB-first
    localparam int TRIGT_LSB    = 0;
    localparam int ENVSTART_LSB = TRIGT_LSB + TCNT_W;
    localparam int ENVLEN_LSB   = ENVSTART_LSB + ENV_W;
    localparam int AMPX_LSB     = ENVLEN_LSB + ENV_W;
    localparam int PINI_LSB     = AMPX_LSB + AMPX_W;
    localparam int FREQ_LSB     = PINI_LSB + PINI_W;
    localparam int MODE_LSB     = FREQ_LSB + FREQ_W;
    localparam int IMM_LSB      = MODE_LSB + MODE_W;
    localparam int CMD_USED_W   = IMM_LSB + 1;

    // Decoded command; first member is the MSB, so trigt lands at bit 0
    typedef struct packed {
        logic              imm;
        logic [MODE_W-1:0] mode;
        logic [FREQ_W-1:0] freqaddr;
        logic [PINI_W-1:0] pini;
        logic [AMPX_W-1:0] ampx;
        logic [ENV_W-1:0]  envlength;
        logic [ENV_W-1:0]  envstart;
        logic [TCNT_W-1:0] trigt;
    } cmd_t;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;

    // Build a full command word from decoded fields; reserved bits are zero
    function automatic logic [CMD_WORD_W-1:0] pack_cmd(input cmd_t c);
        return {{(CMD_WORD_W - CMD_USED_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/elementcmd_fifo.sv
// Synchronous FIFO used as the command buffer. Supports simultaneous push and
// pop (including when full), reports full/empty/level, and has a synchronous
// active-low reset of its pointers.
module elementcmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update on push/pop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    // NOTE: the data array is deliberately not reset; empty pointers make stale
    // contents unreachable, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/elementcmd.sv
// Command issuer for one signal-generation element. Buffers timed command
// words, waits in WAIT until the element time counter reaches the trigger
// time (modular compare), then strobes the registered fields for one cycle.
// Late fires are flagged and counted.
module elementcmd
    import elementcmd_pkg::*;
#(
    parameter int TCNTWIDTH      = 27,
    parameter int ENV_ADDRWIDTH  = 12,
    parameter int FREQ_ADDRWIDTH = 9,
    parameter int DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [127:0]               cmd_data,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [TCNTWIDTH-1:0]       tcnt,
    input  logic                       busy,
    output logic [ENV_ADDRWIDTH-1:0]   envstart,
    output logic [ENV_ADDRWIDTH-1:0]   envlength,
    output logic [AMPX_W-1:0]          ampx,
    output logic [PINI_W-1:0]          pini,
    output logic [FREQ_ADDRWIDTH-1:0]  freqaddr,
    output logic [MODE_W-1:0]          mode,
    output logic                       cmdstb,
    output logic                       reset,
    input  logic                       clr_status,
    output logic                       late,
    output logic [15:0]                late_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    // Field layout derived from this instance's parameters
    localparam int O_ENVSTART = TCNTWIDTH;
    localparam int O_ENVLEN   = O_ENVSTART + ENV_ADDRWIDTH;
    localparam int O_AMPX     = O_ENVLEN + ENV_ADDRWIDTH;
    localparam int O_PINI     = O_AMPX + AMPX_W;
    localparam int O_FREQ     = O_PINI + PINI_W;
    localparam int O_MODE     = O_FREQ + FREQ_ADDRWIDTH;
    localparam int O_IMM      = O_MODE + MODE_W;
    localparam int CMD_W      = O_IMM + 1;

    logic [1:0]       state;
    logic [CMD_W-1:0] head;
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             unused_reserved;

    logic [TCNTWIDTH-1:0]      h_trigt;
    logic [ENV_ADDRWIDTH-1:0]  h_envstart;
    logic [ENV_ADDRWIDTH-1:0]  h_envlength;
    logic [AMPX_W-1:0]         h_ampx;
    logic [PINI_W-1:0]         h_pini;
    logic [FREQ_ADDRWIDTH-1:0] h_freqaddr;
    logic [MODE_W-1:0]         h_mode;
    logic                      h_imm;
    logic [TCNTWIDTH-1:0]      delta;
    logic                      fire_now;
    logic                      late_fire;

    // Reserved upper bits of the command word carry no meaning
    assign unused_reserved = ^cmd_data[127:CMD_W];

    // Input handshake is held off while the element is in reset
    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    // Head reloads from the buffer whenever no command is being timed
    assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || (state == ST_FIRE));

    elementcmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (cmd_data[CMD_W-1:0]),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign h_trigt     = head[TCNTWIDTH-1:0];
    assign h_envstart  = head[O_ENVSTART +: ENV_ADDRWIDTH];
    assign h_envlength = head[O_ENVLEN +: ENV_ADDRWIDTH];
    assign h_ampx      = head[O_AMPX +: AMPX_W];
    assign h_pini      = head[O_PINI +: PINI_W];
    assign h_freqaddr  = head[O_FREQ +: FREQ_ADDRWIDTH];
    assign h_mode      = head[O_MODE +: MODE_W];
    assign h_imm       = head[O_IMM];

    // Modular distance to trigger; MSB set means the trigger is in the past
    assign delta     = h_trigt - tcnt;
    assign fire_now  = (state == ST_WAIT) && !busy &&
                       ((delta == '0) || h_imm || delta[TCNTWIDTH-1]);
    assign late_fire = fire_now && (delta != '0) && !h_imm;

    // FSM, head register, strobe and registered output fields
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            head      <= '0;
            cmdstb    <= 1'b0;
            envstart  <= '0;
            envlength <= '0;
            ampx      <= '0;
            pini      <= '0;
            freqaddr  <= '0;
            mode      <= '0;
        end else begin
            cmdstb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        head  <= fifo_dout;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fire_now) begin
                        state     <= ST_FIRE;
                        cmdstb    <= 1'b1;
                        envstart  <= h_envstart;
                        envlength <= h_envlength;
                        ampx      <= h_ampx;
                        pini      <= h_pini;
                        freqaddr  <= h_freqaddr;
                        mode      <= h_mode;
                    end
                end
                ST_FIRE: begin
                    if (fifo_pop) begin
                        head  <= fifo_dout;
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Late status; a clear is applied first so a same-cycle late fire survives
    always_ff @(posedge clk) begin
        if (!resetn) begin
            late     <= 1'b0;
            late_cnt <= '0;
        end else begin
            if (clr_status) begin
                late     <= 1'b0;
                late_cnt <= '0;
            end
            if (late_fire) begin
                late <= 1'b1;
                if (clr_status)
                    late_cnt <= 16'd1;
                else if (late_cnt != 16'hFFFF)
                    late_cnt <= late_cnt + 16'd1;
            end
        end
    end

    // Element reset follows resetn, inverted and registered
    always_ff @(posedge clk) begin
        reset <= !resetn;
    end

endmodule

// File: tb/tb_elementcmd.sv
// Self-checking bench for elementcmd: a table of single-command vectors
// (timing, fields, late flag) followed by hand-written sequences for reset,
// status clear, busy hold, backpressure ordering and reset mid-WAIT.
module tb_elementcmd;
    import elementcmd_pkg::*;

    logic                clk;
    logic                resetn;
    logic [127:0]        cmd_data;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [TCNT_W-1:0]   tcnt;
    logic                busy;
    logic [ENV_W-1:0]    envstart;
    logic [ENV_W-1:0]    envlength;
    logic [AMPX_W-1:0]   ampx;
    logic [PINI_W-1:0]   pini;
    logic [FREQ_W-1:0]   freqaddr;
    logic [MODE_W-1:0]   mode;
    logic                cmdstb;
    logic                reset;
    logic                clr_status;
    logic                late;
    logic [15:0]         late_cnt;
    logic [2:0]          level;

    int n_checks = 0;
    int n_pass   = 0;

    elementcmd dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .tcnt       (tcnt),
        .busy       (busy),
        .envstart   (envstart),
        .envlength  (envlength),
        .ampx       (ampx),
        .pini       (pini),
        .freqaddr   (freqaddr),
        .mode       (mode),
        .cmdstb     (cmdstb),
        .reset      (reset),
        .clr_status (clr_status),
        .late       (late),
        .late_cnt   (late_cnt),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TCNT_W-1:0] t0;
        cmd_t              cmd;
        logic [TCNT_W-1:0] exp_t;
        logic              exp_late;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic cmd_t mk(input logic [TCNT_W-1:0] trigt, input logic [ENV_W-1:0] es,
                                input logic [ENV_W-1:0] el, input logic [AMPX_W-1:0] ax,
                                input logic [PINI_W-1:0] pi, input logic [FREQ_W-1:0] fa,
                                input logic [MODE_W-1:0] md, input logic im);
        cmd_t c;
        c.trigt = trigt; c.envstart = es; c.envlength = el; c.ampx = ax;
        c.pini = pi; c.freqaddr = fa; c.mode = md; c.imm = im;
        return c;
    endfunction

    // One clock: outputs are sampled 1 time unit after the edge, then tcnt advances
    task automatic tick();
        @(posedge clk);
        #1;
        tcnt = tcnt + 27'd1;
    endtask

    task automatic push_cmd(input cmd_t c);
        logic ok;
        ok = 1'b0;
        cmd_data  = pack_cmd(c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_strobe(input int budget, output logic found, output logic [TCNT_W-1:0] t_at);
        found = 1'b0;
        t_at  = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cmdstb === 1'b1) begin
                found = 1'b1;
                t_at  = tcnt;
                return;
            end
        end
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        logic found;
        logic [TCNT_W-1:0] t_at;
        int   n_stb;
        int   adjacent;
        logic prev_stb;
        logic [AMPX_W-1:0] seen [5];
        logic saw;

        // Single-command vectors: push at t0, expect strobe with tcnt == exp_t
        vecs[0] = '{t0: 27'd50,   cmd: mk(27'd100, 12'h010, 12'h020, 16'h7fff, 17'h1abcd, 9'h155, 2'd2, 1'b0), exp_t: 27'd101, exp_late: 1'b0};
        vecs[1] = '{t0: 27'd40,   cmd: mk(27'd10,  12'habc, 12'h123, 16'h8001, 17'h00001, 9'h1ff, 2'd1, 1'b0), exp_t: 27'd43,  exp_late: 1'b1};
        vecs[2] = '{t0: 27'd1000, cmd: mk(27'd5000, 12'h001, 12'h002, 16'h0003, 17'h10004, 9'h005, 2'd0, 1'b1), exp_t: 27'd1003, exp_late: 1'b0};
        vecs[3] = '{t0: 27'd300,  cmd: mk(27'd302, 12'h3c3, 12'h5a5, 16'h1234, 17'h0abcd, 9'h0aa, 2'd3, 1'b0), exp_t: 27'd303, exp_late: 1'b0};
        vecs[4] = '{t0: 27'd300,  cmd: mk(27'd301, 12'h777, 12'h888, 16'h4321, 17'h15555, 9'h123, 2'd2, 1'b0), exp_t: 27'd303, exp_late: 1'b1};
        vecs[5] = '{t0: 27'h7fffffd, cmd: mk(27'd2, 12'h0f0, 12'h00f, 16'hbeef, 17'h0cafe, 9'h0ff, 2'd1, 1'b0), exp_t: 27'd3, exp_late: 1'b0};
        vecs[6] = '{t0: 27'd0,    cmd: mk(27'h4000002, 12'h100, 12'h200, 16'h0400, 17'h00800, 9'h010, 2'd0, 1'b0), exp_t: 27'd3, exp_late: 1'b1};
        vecs[7] = '{t0: 27'd7,    cmd: mk(27'd0, 12'hfff, 12'hfff, 16'hffff, 17'h1ffff, 9'h000, 2'd3, 1'b1), exp_t: 27'd10, exp_late: 1'b0};

        resetn = 1'b0; cmd_data = '0; cmd_valid = 1'b0; tcnt = '0;
        busy = 1'b0; clr_status = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cmdstb", 32'(cmdstb), 32'd0);
        check("rst_envstart", 32'(envstart), 32'd0);
        check("rst_ampx", 32'(ampx), 32'd0);
        check("rst_late", 32'(late), 32'd0);
        check("rst_late_cnt", 32'(late_cnt), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_reset_out", 32'(reset), 32'd1);
        resetn = 1'b1;
        tick();
        check("rel_reset_out", 32'(reset), 32'd0);
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table-driven single commands
        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            tcnt = vecs[i].t0;
            push_cmd(vecs[i].cmd);
            wait_strobe(200, found, t_at);
            check($sformatf("v%0d_strobe", i), 32'(found), 32'd1);
            check($sformatf("v%0d_tcnt", i), 32'(t_at), 32'(vecs[i].exp_t));
            check($sformatf("v%0d_envstart", i), 32'(envstart), 32'(vecs[i].cmd.envstart));
            check($sformatf("v%0d_envlength", i), 32'(envlength), 32'(vecs[i].cmd.envlength));
            check($sformatf("v%0d_ampx", i), 32'(ampx), 32'(vecs[i].cmd.ampx));
            check($sformatf("v%0d_pini", i), 32'(pini), 32'(vecs[i].cmd.pini));
            check($sformatf("v%0d_freqaddr", i), 32'(freqaddr), 32'(vecs[i].cmd.freqaddr));
            check($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].cmd.mode));
            check($sformatf("v%0d_late", i), 32'(late), 32'(vecs[i].exp_late));
            tick();
            check($sformatf("v%0d_stb_one_cycle", i), 32'(cmdstb), 32'd0);
            check($sformatf("v%0d_hold_ampx", i), 32'(ampx), 32'(vecs[i].cmd.ampx));
        end

        // Two late fires count to 2, then a clear coinciding with a late fire
        pulse_clr();
        for (int k = 0; k < 2; k++) begin
            tcnt = 27'd500;
            push_cmd(mk(27'd1, 12'h0, 12'h0, 16'h0, 17'h0, 9'h0, 2'd0, 1'b0));
            wait_strobe(20, found, t_at);
            tick();
        end
        check("late_cnt_two", 32'(late_cnt), 32'd2);
        check("late_set", 32'(late), 32'd1);
        tcnt = 27'd600;
        push_cmd(mk(27'd1, 12'h0, 12'h0, 16'h0, 17'h0, 9'h0, 2'd0, 1'b0));
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("clr_late_stb", 32'(cmdstb), 32'd1);
        check("clr_late_flag", 32'(late), 32'd1);
        check("clr_late_cnt", 32'(late_cnt), 32'd1);
        tick();
        pulse_clr();
        check("clr_flag", 32'(late), 32'd0);
        check("clr_cnt", 32'(late_cnt), 32'd0);

        // Busy held across the trigger time, released at tcnt == 205
        tcnt = 27'd150;
        busy = 1'b1;
        push_cmd(mk(27'd200, 12'h0aa, 12'h0bb, 16'h0ccc, 17'h0dddd, 9'h0ee, 2'd1, 1'b0));
        saw = 1'b0;
        for (int i = 0; i < 100 && tcnt != 27'd205; i++) begin
            tick();
            if (cmdstb === 1'b1) saw = 1'b1;
        end
        check("busy_no_early_stb", 32'(saw), 32'd0);
        check("busy_reached_205", 32'(tcnt), 32'd205);
        busy = 1'b0;
        tick();
        check("busy_stb", 32'(cmdstb), 32'd1);
        check("busy_stb_tcnt", 32'(tcnt), 32'd206);
        check("busy_late", 32'(late), 32'd1);
        check("busy_ampx", 32'(ampx), 32'h0ccc);
        tick();

        // Backpressure: five immediate commands buffered while busy
        busy = 1'b1;
        for (int i = 0; i < 5; i++)
            push_cmd(mk(27'd0, 12'h0, 12'h0, 16'(i + 1), 17'h0, 9'h0, 2'd0, 1'b1));
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_data  = pack_cmd(mk(27'd0, 12'h0, 12'h0, 16'h0099, 17'h0, 9'h0, 2'd0, 1'b1));
        cmd_valid = 1'b1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        check("full_level_hold", 32'(level), 32'd4);
        busy = 1'b0;
        n_stb = 0; adjacent = 0; prev_stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cmdstb === 1'b1) begin
                if (prev_stb) adjacent++;
                if (n_stb < 5) seen[n_stb] = ampx;
                n_stb++;
            end
            prev_stb = (cmdstb === 1'b1);
        end
        check("drain_count", 32'(n_stb), 32'd5);
        check("drain_adjacent", 32'(adjacent), 32'd0);
        for (int i = 0; i < 5; i++)
            check($sformatf("drain_order%0d", i), 32'(seen[i]), 32'(i + 1));
        check("drain_level", 32'(level), 32'd0);

        // Reset while an immediate command waits behind busy
        busy = 1'b1;
        push_cmd(mk(27'd0, 12'h0, 12'h0, 16'h0055, 17'h0, 9'h0, 2'd0, 1'b1));
        push_cmd(mk(27'd0, 12'h0, 12'h0, 16'h0066, 17'h0, 9'h0, 2'd0, 1'b1));
        tick();
        check("pre_rst_level", 32'(level), 32'd1);
        resetn = 1'b0;
        busy   = 1'b0;
        tick();
        check("mid_rst_stb", 32'(cmdstb), 32'd0);
        check("mid_rst_ampx", 32'(ampx), 32'd0);
        check("mid_rst_reset_out", 32'(reset), 32'd1);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_late", 32'(late), 32'd0);
        check("mid_rst_late_cnt", 32'(late_cnt), 32'd0);
        resetn = 1'b1;
        tick();
        check("post_rst_reset_out", 32'(reset), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmdstb === 1'b1) saw = 1'b1;
        end
        check("post_rst_no_stb", 32'(saw), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
